// File: rtl/multi_chan_pwm.sv
// N-channel PWM generator with one shared period counter.
// Duty and period changes take effect only at a period boundary, so reprogramming cannot glitch.
module multi_chan_pwm #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     period,
  input  logic [NCH*WIDTH-1:0] duty,
  input  logic                 load,
  output logic [NCH-1:0]       pwm_out,
  output logic                 cycle_start
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] period_act_q;
  logic [WIDTH-1:0] duty_sh_q  [NCH];
  logic [WIDTH-1:0] duty_act_q [NCH];
  logic [WIDTH-1:0] duty_nxt   [NCH];
  logic [NCH-1:0]   pwm_d;
  logic             boundary;
  logic             reload;

  always_comb begin
    boundary = en && (cnt_q == period_act_q);
    // Active values are transparent while disabled and latched once per period while running.
    reload   = !en || boundary;
    for (int unsigned i = 0; i < NCH; i++) begin
      duty_nxt[i] = load ? duty[i*WIDTH +: WIDTH] : duty_sh_q[i];
      pwm_d[i]    = en && (cnt_q < duty_act_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      period_act_q <= '1;
      pwm_out      <= '0;
      cycle_start  <= 1'b0;
    end else begin
      pwm_out     <= pwm_d;
      cycle_start <= en && (cnt_q == '0);
      if (reload) begin
        cnt_q        <= '0;
        period_act_q <= period;
      end else begin
        cnt_q <= cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (load) begin
          duty_sh_q[i] <= duty[i*WIDTH +: WIDTH];
        end
        if (reload) begin
          duty_act_q[i] <= duty_nxt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_chan_pwm.sv
// Directed bench for multi_chan_pwm (WIDTH=8, NCH=2): vector table plus period-measurement sequences.
module tb_multi_chan_pwm;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  period;
  logic [15:0] duty;
  logic        load;
  logic [1:0]  pwm_out;
  logic        cycle_start;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit         en;
    bit         ld;
    logic [7:0] per;
    logic [7:0] d1;
    logic [7:0] d0;
    logic [1:0] pwm;
    bit         cs;
  } vec_t;

  vec_t vecs[$];

  multi_chan_pwm #(
    .WIDTH(8),
    .NCH  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .period     (period),
    .duty       (duty),
    .load       (load),
    .pwm_out    (pwm_out),
    .cycle_start(cycle_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit e, input bit l, input logic [7:0] p, input logic [7:0] d1,
                     input logic [7:0] d0, input logic [1:0] pw, input bit c);
    vec_t v;
    v.en = e; v.ld = l; v.per = p; v.d1 = d1; v.d0 = d0; v.pwm = pw; v.cs = c;
    vecs.push_back(v);
  endtask

  task automatic wait_cs(input int limit);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!cycle_start && n < limit);
    check("wait_cs", int'(cycle_start), 1);
  endtask

  // Starts on the sample where cycle_start is high; returns on the next one.
  // At count act_at the given period/duty/load are driven for one edge.
  task automatic measure(input int act_at, input logic [7:0] np, input logic [15:0] nd,
                         input bit nl, output int len, output int h0, output int h1,
                         output int rises);
    logic [1:0] prev;
    len = 0; h0 = 0; h1 = 0; rises = 0; prev = 2'b00;
    forever begin
      if (pwm_out[0]) h0++;
      if (pwm_out[1]) h1++;
      if (len > 0 && ((pwm_out & ~prev) != 2'b00)) rises++;
      prev = pwm_out;
      len++;
      if (len == act_at) begin
        period = np;
        duty   = nd;
        load   = nl;
      end
      tick();
      load = 1'b0;
      if (cycle_start || len > 400) break;
    end
  endtask

  task automatic check_period(input string name, input int act_at, input logic [7:0] np,
                              input logic [15:0] nd, input bit nl, input int e_len,
                              input int e_h0, input int e_h1);
    int len, h0, h1, rises;
    measure(act_at, np, nd, nl, len, h0, h1, rises);
    check({name, " len"}, len, e_len);
    check({name, " ch0 high"}, h0, e_h0);
    check({name, " ch1 high"}, h1, e_h1);
    check({name, " late rises"}, rises, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    load   = 1'b0;
    period = 8'd0;
    duty   = 16'd0;

    // Reset state
    tick();
    tick();
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset cycle_start", int'(cycle_start), 0);
    check("reset cnt", int'(dut.cnt_q), 0);
    #2 rst_n = 1'b1;

    // Basic run: period 9, ch0 duty 3, ch1 duty 7
    add(0, 1, 9, 7, 3, 2'b00, 0);
    add(0, 0, 9, 7, 3, 2'b00, 0);
    add(1, 0, 9, 7, 3, 2'b11, 1);
    add(1, 0, 9, 7, 3, 2'b11, 0);
    add(1, 0, 9, 7, 3, 2'b11, 0);
    add(1, 0, 9, 7, 3, 2'b10, 0);
    add(1, 0, 9, 7, 3, 2'b10, 0);
    add(1, 0, 9, 7, 3, 2'b10, 0);
    add(1, 0, 9, 7, 3, 2'b10, 0);
    add(1, 0, 9, 7, 3, 2'b00, 0);
    add(1, 0, 9, 7, 3, 2'b00, 0);
    add(1, 0, 9, 7, 3, 2'b00, 0);
    add(1, 0, 9, 7, 3, 2'b11, 1);
    add(1, 0, 9, 7, 3, 2'b11, 0);
    foreach (vecs[k]) begin
      en     = vecs[k].en;
      load   = vecs[k].ld;
      period = vecs[k].per;
      duty   = {vecs[k].d1, vecs[k].d0};
      tick();
      check($sformatf("vec%0d pwm_out", k), int'(pwm_out), int'(vecs[k].pwm));
      check($sformatf("vec%0d cycle_start", k), int'(cycle_start), int'(vecs[k].cs));
    end
    load = 1'b0;

    // Mid-period duty load at cnt=4
    wait_cs(20);
    check_period("load@4 cur", 4, 8'd9, {8'd7, 8'd5}, 1'b1, 10, 3, 7);
    check_period("load@4 next", -1, 8'd9, {8'd7, 8'd5}, 1'b0, 10, 5, 7);

    // Period change 9->4 at cnt=2; ch1 duty 7 > P=4 stays high across the wrap
    check_period("per@2 cur", 2, 8'd4, {8'd7, 8'd5}, 1'b0, 10, 5, 7);
    check_period("per4 a", 1, 8'd9, {8'd255, 8'd0}, 1'b1, 5, 5, 5);

    // Duty 0 and 255 with period 9 over five periods
    for (int p = 0; p < 5; p++) begin
      check_period($sformatf("extreme p%0d", p), -1, 8'd9, {8'd255, 8'd0}, 1'b0, 10, 0, 10);
    end

    // Drop en at cnt=5 for three clocks, reprogram while idle, then restart
    repeat (4) tick();
    en = 1'b0;
    tick();
    check("en fall pwm_out", int'(pwm_out), 0);
    check("en fall cycle_start", int'(cycle_start), 0);
    duty = {8'd7, 8'd3};
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("en low pwm_out", int'(pwm_out), 0);
    check("en low cycle_start", int'(cycle_start), 0);
    en = 1'b1;
    tick();
    check("en rise cycle_start", int'(cycle_start), 1);
    check("en rise pwm_out", int'(pwm_out), 3);
    check_period("restart", -1, 8'd9, {8'd7, 8'd3}, 1'b0, 10, 3, 7);

    // Async reset while outputs are high, no clock edge in between
    tick();
    check("pre-reset pwm_out", int'(pwm_out), 3);
    #2 rst_n = 1'b0;
    #1;
    check("async reset pwm_out", int'(pwm_out), 0);
    check("async reset cycle_start", int'(cycle_start), 0);
    check("async reset cnt", int'(dut.cnt_q), 0);
    #2 rst_n = 1'b1;
    tick();
    check("post-reset cycle_start", int'(cycle_start), 1);
    check("post-reset pwm_out", int'(pwm_out), 0);
    check_period("post-reset all-ones", -1, 8'd9, {8'd7, 8'd3}, 1'b0, 256, 0, 0);
    check_period("post-reset p9", -1, 8'd9, {8'd7, 8'd3}, 1'b0, 10, 0, 0);

    // Period 0 with duty 1: both outputs and cycle_start held high
    en     = 1'b0;
    period = 8'd0;
    duty   = {8'd1, 8'd1};
    load   = 1'b1;
    tick();
    load = 1'b0;
    tick();
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("p0 clk%0d pwm_out", k), int'(pwm_out), 3);
      check($sformatf("p0 clk%0d cycle_start", k), int'(cycle_start), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
